// File: rtl/icecream_vend_if.sv
// Selection/coin/refund signals of the ice-cream vending controller.
// The master drives the user side; the slave is the controller.
interface icecream_vend_if;
    logic       sel_valid;
    logic [3:0] sel;
    logic       coin_valid;
    logic [2:0] coin_amt;
    logic       cancel;
    logic       dispense;
    logic       refund_valid;
    logic [5:0] refund_amt;
    logic       reject;
    logic       busy;
    logic [5:0] credit;
    logic [3:0] order_sel;

    modport master (
        output sel_valid, sel, coin_valid, coin_amt, cancel,
        input  dispense, refund_valid, refund_amt, reject, busy, credit, order_sel
    );

    modport slave (
        input  sel_valid, sel, coin_valid, coin_amt, cancel,
        output dispense, refund_valid, refund_amt, reject, busy, credit, order_sel
    );
endinterface

// File: rtl/icecream_vend_ctrl.sv
// Ice-cream vending controller: selection check, coin collection with timeout,
// timed dispense pulse and a single-cycle refund of any change. All outputs registered.
module icecream_vend_ctrl #(
    parameter int PRICE       = 10,
    parameter int TIMEOUT     = 200,
    parameter int DISP_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    icecream_vend_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PAY, DISPENSE, REFUND} state_e;

    localparam logic [5:0] PRICE_C   = 6'(PRICE);
    localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [3:0] DISP_LAST = 4'(DISP_CYCLES - 1);

    state_e     state_q;
    logic [5:0] credit_q;
    logic [5:0] refund_amt_q;
    logic [9:0] tmo_q;
    logic [3:0] dcnt_q;
    logic [3:0] sel_q;
    logic       dispense_q;
    logic       refund_valid_q;
    logic       reject_q;
    logic       busy_q;

    logic       sel_legal;
    logic       coin_ok;
    logic [6:0] sum;
    logic [5:0] credit_d;

    always_comb begin
        sel_legal = 1'b0;
        case (bus.sel)
            4'b1100, 4'b0101, 4'b0011, 4'b0110, 4'b1010: sel_legal = 1'b1;
            default:                                     sel_legal = 1'b0;
        endcase
    end

    assign coin_ok  = bus.coin_valid && (bus.coin_amt != 3'd0);
    assign sum      = {1'b0, credit_q} + (coin_ok ? {4'd0, bus.coin_amt} : 7'd0);
    // sum never exceeds 63+7, so bit 6 alone marks overflow past 63
    assign credit_d = sum[6] ? 6'd63 : sum[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= 6'd0;
            refund_amt_q   <= 6'd0;
            tmo_q          <= 10'd0;
            dcnt_q         <= 4'd0;
            sel_q          <= 4'd0;
            dispense_q     <= 1'b0;
            refund_valid_q <= 1'b0;
            reject_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            reject_q       <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= 6'd0;
            case (state_q)
                IDLE: begin
                    if (bus.sel_valid) begin
                        if (sel_legal) begin
                            sel_q    <= bus.sel;
                            credit_q <= 6'd0;
                            tmo_q    <= 10'd0;
                            busy_q   <= 1'b1;
                            state_q  <= PAY;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                PAY: begin
                    // coins are credited even on the cycle that cancels or completes payment
                    credit_q <= credit_d;
                    tmo_q    <= coin_ok ? 10'd0 : tmo_q + 10'd1;
                    if (credit_q >= PRICE_C) begin
                        dcnt_q     <= 4'd0;
                        dispense_q <= 1'b1;
                        state_q    <= DISPENSE;
                    end else if (bus.cancel || (!coin_ok && tmo_q == TMO_LAST)) begin
                        refund_valid_q <= 1'b1;
                        refund_amt_q   <= credit_d;
                        state_q        <= REFUND;
                    end
                end
                DISPENSE: begin
                    if (dcnt_q == DISP_LAST) begin
                        dispense_q     <= 1'b0;
                        refund_valid_q <= 1'b1;
                        refund_amt_q   <= credit_q - PRICE_C;
                        state_q        <= REFUND;
                    end else begin
                        dcnt_q <= dcnt_q + 4'd1;
                    end
                end
                REFUND: begin
                    credit_q <= 6'd0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dispense     = dispense_q;
    assign bus.refund_valid = refund_valid_q;
    assign bus.refund_amt   = refund_amt_q;
    assign bus.reject       = reject_q;
    assign bus.busy         = busy_q;
    assign bus.credit       = credit_q;
    assign bus.order_sel    = sel_q;
endmodule

// File: tb/tb_icecream_vend_ctrl.sv
// Bench for icecream_vend_ctrl: cycle table, directed corner sequences and
// random orders checked against an order-level outcome model.
module tb_icecream_vend_ctrl;
    localparam int PRICE = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icecream_vend_if bus ();
    icecream_vend_if bus2 ();

    icecream_vend_ctrl #(.PRICE(PRICE), .TIMEOUT(200), .DISP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    icecream_vend_ctrl #(.PRICE(63), .TIMEOUT(5), .DISP_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        logic       sv;
        logic [3:0] sel;
        logic       cv;
        logic [2:0] amt;
        logic       cn;
        logic       disp;
        logic       rv;
        logic [5:0] ramt;
        logic       rej;
        logic       busy;
        logic [5:0] cr;
        logic [3:0] osel;
    } vec_t;

    vec_t tv[25];
    int total = 0;
    int bad = 0;
    int disp_cnt, ref_cnt, rej_cnt, ref_amt;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic vec_t row(input int sv, sel, cv, amt, cn, disp, rv, ramt, rej, busy, cr, osel);
        vec_t v;
        v.sv = 1'(sv);   v.sel = 4'(sel); v.cv = 1'(cv);     v.amt = 3'(amt);
        v.cn = 1'(cn);   v.disp = 1'(disp); v.rv = 1'(rv);   v.ramt = 6'(ramt);
        v.rej = 1'(rej); v.busy = 1'(busy); v.cr = 6'(cr);   v.osel = 4'(osel);
        return v;
    endfunction

    function automatic int outs();
        return int'({bus.dispense, bus.refund_valid, bus.refund_amt, bus.reject,
                     bus.busy, bus.credit, bus.order_sel});
    endfunction

    function automatic int expd(input vec_t v);
        return int'({v.disp, v.rv, v.ramt, v.rej, v.busy, v.cr, v.osel});
    endfunction

    // legal codes: exactly two bits set, except the Sa+P pairing
    function automatic bit is_legal(input logic [3:0] s);
        return ($countones(s) == 2) && (s != 4'b1001);
    endfunction

    task automatic drive(input int sv, input int s, input int cv, input int a, input int cn);
        bus.sel_valid  = 1'(sv);
        bus.sel        = 4'(s);
        bus.coin_valid = 1'(cv);
        bus.coin_amt   = 3'(a);
        bus.cancel     = 1'(cn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.dispense) disp_cnt++;
        if (bus.reject) rej_cnt++;
        if (bus.refund_valid) begin
            ref_cnt++;
            ref_amt = int'(bus.refund_amt);
        end
        chk("refund_amt_quiet", bus.refund_valid ? 0 : int'(bus.refund_amt), 0);
    endtask

    task automatic clr_mon();
        disp_cnt = 0; ref_cnt = 0; rej_cnt = 0; ref_amt = -1;
    endtask

    task automatic tick2();
        @(posedge clk);
        #1;
    endtask

    task automatic run_order();
        logic [3:0] s;
        int sum, a, n;
        bit cxl, cmode;
        s = 4'($urandom_range(0, 15));
        clr_mon();
        drive(1, int'(s), 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        if (!is_legal(s)) begin
            tick();
            chk("rnd_reject", rej_cnt, 1);
            chk("rnd_reject_busy", int'(bus.busy), 0);
            return;
        end
        chk("rnd_osel", int'(bus.order_sel), int'(s));
        cmode = ($urandom_range(0, 3) == 0);
        sum = 0;
        cxl = 1'b0;
        while (sum < PRICE && !cxl) begin
            repeat ($urandom_range(0, 3)) begin
                drive(1, $urandom_range(0, 15), 0, 0, 0);
                tick();
            end
            a = $urandom_range(0, 7);
            cxl = cmode && ($urandom_range(0, 2) == 0);
            drive(0, 0, 1, a, int'(cxl));
            tick();
            sum = (sum + a > 63) ? 63 : sum + a;
        end
        drive(0, 0, 0, 0, 0);
        n = 0;
        if (!cxl) begin
            tick();
            while (bus.busy && n < 40) begin
                drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 1));
                tick();
                n++;
            end
        end else begin
            while (bus.busy && n < 40) begin
                tick();
                n++;
            end
        end
        drive(0, 0, 0, 0, 0);
        chk("rnd_end_idle", int'(bus.busy), 0);
        chk("rnd_disp_cycles", disp_cnt, cxl ? 0 : 4);
        chk("rnd_refund_count", ref_cnt, 1);
        chk("rnd_refund_amt", ref_amt, cxl ? sum : sum - PRICE);
        chk("rnd_no_reject", rej_cnt, 0);
        chk("rnd_osel_kept", int'(bus.order_sel), int'(s));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tv[0]  = row(1, 'b1100, 0, 0, 0,  0, 0, 0, 0, 1,  0, 'b1100);
        tv[1]  = row(0, 0,      1, 5, 0,  0, 0, 0, 0, 1,  5, 'b1100);
        tv[2]  = row(0, 0,      1, 5, 0,  0, 0, 0, 0, 1, 10, 'b1100);
        tv[3]  = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 10, 'b1100);
        tv[4]  = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 10, 'b1100);
        tv[5]  = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 10, 'b1100);
        tv[6]  = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 10, 'b1100);
        tv[7]  = row(0, 0,      0, 0, 0,  0, 1, 0, 0, 1, 10, 'b1100);
        tv[8]  = row(0, 0,      0, 0, 0,  0, 0, 0, 0, 0,  0, 'b1100);
        tv[9]  = row(1, 'b1111, 0, 0, 0,  0, 0, 0, 1, 0,  0, 'b1100);
        tv[10] = row(0, 0,      1, 5, 0,  0, 0, 0, 0, 0,  0, 'b1100);
        tv[11] = row(0, 0,      1, 7, 0,  0, 0, 0, 0, 0,  0, 'b1100);
        tv[12] = row(1, 'b0101, 0, 0, 0,  0, 0, 0, 0, 1,  0, 'b0101);
        tv[13] = row(1, 'b1111, 1, 7, 0,  0, 0, 0, 0, 1,  7, 'b0101);
        tv[14] = row(0, 0,      1, 7, 0,  0, 0, 0, 0, 1, 14, 'b0101);
        tv[15] = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 14, 'b0101);
        tv[16] = row(0, 0,      1, 7, 1,  1, 0, 0, 0, 1, 14, 'b0101);
        tv[17] = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 14, 'b0101);
        tv[18] = row(0, 0,      0, 0, 0,  1, 0, 0, 0, 1, 14, 'b0101);
        tv[19] = row(0, 0,      0, 0, 0,  0, 1, 4, 0, 1, 14, 'b0101);
        tv[20] = row(0, 0,      0, 0, 0,  0, 0, 0, 0, 0,  0, 'b0101);
        tv[21] = row(1, 'b0011, 0, 0, 0,  0, 0, 0, 0, 1,  0, 'b0011);
        tv[22] = row(0, 0,      1, 3, 0,  0, 0, 0, 0, 1,  3, 'b0011);
        tv[23] = row(0, 0,      1, 2, 1,  0, 1, 5, 0, 1,  5, 'b0011);
        tv[24] = row(0, 0,      0, 0, 0,  0, 0, 0, 0, 0,  0, 'b0011);

        drive(0, 0, 0, 0, 0);
        bus2.sel_valid = 1'b0; bus2.sel = 4'd0; bus2.coin_valid = 1'b0;
        bus2.coin_amt = 3'd0;  bus2.cancel = 1'b0;
        clr_mon();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(int'(tv[i].sv), int'(tv[i].sel), int'(tv[i].cv), int'(tv[i].amt), int'(tv[i].cn));
            tick();
            chk($sformatf("vec%0d", i), outs(), expd(tv[i]));
        end
        drive(0, 0, 0, 0, 0);

        // coin-less timeout, with a coin landing on the last safe cycle
        clr_mon();
        drive(1, 'b1010, 0, 0, 0); tick();
        drive(0, 0, 1, 4, 0);      tick();
        drive(0, 0, 0, 0, 0);
        repeat (199) tick();
        drive(0, 0, 1, 1, 0);      tick();
        drive(0, 0, 0, 0, 0);
        chk("tmo_restart_no_refund", ref_cnt, 0);
        chk("tmo_restart_credit", int'(bus.credit), 5);
        n = 0;
        while (!bus.refund_valid && n < 300) begin tick(); n++; end
        chk("tmo_cycles", n, 200);
        chk("tmo_amt", int'(bus.refund_amt), 5);
        chk("tmo_no_dispense", disp_cnt, 0);
        tick();
        chk("tmo_back_idle", int'(bus.busy), 0);

        // PRICE=63 instance: saturation and minimum dispense length
        bus2.sel_valid = 1'b1; bus2.sel = 4'b1100; tick2();
        bus2.sel_valid = 1'b0; bus2.coin_valid = 1'b1; bus2.coin_amt = 3'd7;
        repeat (9) tick2();
        chk("sat_credit_63", int'(bus2.credit), 63);
        chk("sat_not_yet_disp", int'(bus2.dispense), 0);
        tick2();
        chk("sat_hold_63", int'(bus2.credit), 63);
        chk("sat_dispense", int'(bus2.dispense), 1);
        bus2.coin_valid = 1'b0;
        tick2();
        chk("sat_disp_one_cycle", int'(bus2.dispense), 0);
        chk("sat_zero_refund_pulse", int'(bus2.refund_valid), 1);
        chk("sat_zero_refund_amt", int'(bus2.refund_amt), 0);
        tick2();
        chk("sat_idle_credit", int'(bus2.credit), 0);
        bus2.sel_valid = 1'b1; bus2.sel = 4'b0110; tick2();
        bus2.sel_valid = 1'b0;
        n = 0;
        while (!bus2.refund_valid && n < 20) begin tick2(); n++; end
        chk("tmo5_cycles", n, 5);
        chk("tmo5_amt", int'(bus2.refund_amt), 0);

        // reset in the middle of PAY
        clr_mon();
        drive(1, 'b0110, 0, 0, 0); tick();
        drive(0, 0, 1, 6, 0);      tick();
        drive(0, 0, 0, 0, 0);
        chk("rst_pre_credit", int'(bus.credit), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", outs(), 0);
        tick(); tick();
        chk("rst_no_refund", ref_cnt, 0);
        chk("rst_held_outputs", outs(), 0);
        @(negedge clk) rst_n = 1'b1;
        clr_mon();
        drive(1, 'b0110, 0, 0, 0); tick();
        drive(0, 0, 1, 6, 0);      tick();
        tick();
        drive(0, 0, 0, 0, 0);
        n = 0;
        while (bus.busy && n < 40) begin tick(); n++; end
        chk("post_rst_disp", disp_cnt, 4);
        chk("post_rst_refund", ref_amt, 2);
        chk("post_rst_idle", int'(bus.busy), 0);

        for (int k = 0; k < 60; k++) run_order();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icecream_vend_ctrl.md
ICECREAM_VEND_CTRL -- requirements
Module: icecream_vend_ctrl

Interface
REQ-001 Parameter PRICE, default 10, cone price in credit units, legal 1..63.
REQ-002 Parameter TIMEOUT, default 200, consecutive coin-less cycles in PAY before the order auto-cancels, legal 1..1023.
REQ-003 Parameter DISP_CYCLES, default 4, length in cycles of the dispense pulse, legal 1..15.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sel_valid  input  1  selection strobe; sel is sampled when high.
REQ-007 sel  input  4  {Sa,Sw,I,P} topping/flavour selection bits, Sa = bit 3.
REQ-008 coin_valid  input  1  one-cycle coin strobe.
REQ-009 coin_amt  input  3  coin value in credit units; 0 is ignored.
REQ-010 cancel  input  1  user abort request.
REQ-011 dispense  output  1  high for exactly DISP_CYCLES cycles per served order.
REQ-012 refund_valid  output  1  one-cycle strobe qualifying refund_amt.
REQ-013 refund_amt  output  6  credit returned, valid only with refund_valid.
REQ-014 reject  output  1  one-cycle pulse: illegal selection.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 credit  output  6  registered running credit of the current order.

Function
REQ-017 States are IDLE, PAY, DISPENSE and REFUND; the FSM transitions only on rising clk.
REQ-018 Legal {Sa,Sw,I,P} combinations are exactly 1100, 0101, 0011, 0110 and 1010; all other 11 codes are illegal.
REQ-019 In IDLE, sel_valid with a legal sel latches sel and goes to PAY on the next edge.
REQ-020 In IDLE, sel_valid with an illegal sel pulses reject in the following cycle and stays in IDLE.
REQ-021 sel_valid outside IDLE is ignored; the latched selection does not change.
REQ-022 In PAY, coin_valid with nonzero coin_amt adds coin_amt to credit, saturating at 63.
REQ-023 In PAY, when the registered credit is >= PRICE, the FSM goes to DISPENSE on the next edge.
REQ-024 In PAY, cancel, or TIMEOUT consecutive cycles without an accepted coin, goes to REFUND.
REQ-025 In PAY, cancel together with coin_valid in the same cycle credits the coin first, then goes to REFUND.
REQ-026 The coin-less timeout counter clears on entry to PAY and on every accepted coin.
REQ-027 In DISPENSE, dispense is held high for DISP_CYCLES cycles.
REQ-028 cancel and coins are ignored in DISPENSE; coins offered there are not credited.
REQ-029 After DISPENSE, go to REFUND with refund amount = credit - PRICE.
REQ-030 In REFUND, refund_valid pulses for one cycle with the amount.
REQ-031 In REFUND, the amount is the full credit when entered from PAY and credit - PRICE when entered from DISPENSE.
REQ-032 A zero refund amount still produces the refund_valid pulse, with refund_amt = 0.
REQ-033 REFUND lasts one cycle, then the FSM returns to IDLE with credit cleared to 0.
REQ-034 refund_amt reads 0 whenever refund_valid is low.
REQ-035 All outputs are registered.

Reset
REQ-036 Asserting rst_n low immediately forces IDLE and clears credit, the timeout counter, the dispense counter and the latched selection.
REQ-037 During reset, dispense, refund_valid, refund_amt, reject, busy and credit are all 0.
REQ-038 Reset during PAY or DISPENSE discards credit with no refund pulse.
REQ-039 Operation resumes on the first rising clk edge after rst_n deasserts.

Verification
REQ-040 sel=1100 legal, coins 5,5 with PRICE=10 -> credit 5 then 10; dispense high 4 cycles; refund_valid with refund_amt=0; back to IDLE.
REQ-041 sel=1111 -> reject pulses once; busy stays 0; later coins are ignored and credit stays 0.
REQ-042 sel=0101, coins 7,7 -> credit 14; dispense; refund_amt=4.
REQ-043 sel=0011, coin 3, then cancel asserted in the same cycle as a coin of 2 -> REFUND, refund_amt=5, no dispense.
REQ-044 sel=1010, coin 4, then no coins for 200 cycles -> refund_amt=4 on the timeout cycle.
REQ-045 sel=0110, coin 6, rst_n pulsed low mid-PAY -> all outputs 0 at once, no refund_valid pulse; a new order then completes normally.
